// File: rtl/nbit_rr_mux.sv
// nbit_rr_mux: merges 2**SELECT_WIDTH single-bit sources into one registered
// output stream with a valid/ready handshake. Each transfer carries the data
// bit plus the index of the source that supplied it.
//
// Arbitration:
//   default                     - round-robin. The scan starts one index past
//                                 the last grant, so a source that keeps its
//                                 request high ranks behind every other source.
//   MUX_FIXED_PRIORITY_EN       - fixed priority, lowest index wins; no
//                                 last-grant state is kept.
//
// A grant loads whenever some source requests and the output register is
// either empty or being drained in the same cycle. The granted source gets a
// one-cycle one-hot MuxAck pulse together with the load.

module nbit_rr_mux #(
    parameter int SELECT_WIDTH = 4
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic [(1<<SELECT_WIDTH)-1:0]  MuxReq,
    input  logic [(1<<SELECT_WIDTH)-1:0]  MuxIn,
    output logic [(1<<SELECT_WIDTH)-1:0]  MuxAck,
    output logic                          MuxOut,
    output logic [SELECT_WIDTH-1:0]       MuxSel,
    output logic                          MuxOutValid,
    input  logic                          MuxOutReady
);

    localparam int N = 1 << SELECT_WIDTH;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                  r_state;
    logic                    r_out;
    logic [SELECT_WIDTH-1:0] r_sel;
    logic [N-1:0]            r_ack;

    logic                    w_any_req;
    logic                    w_load;
    logic [SELECT_WIDTH-1:0] w_grant;
    logic [N-1:0]            w_grant_onehot;

    // A new transfer can enter when the register is empty or drains this cycle;
    // a ready asserted while empty has no effect.
    assign w_any_req = |MuxReq;
    assign w_load    = w_any_req && ((r_state == ST_EMPTY) || MuxOutReady);

`ifdef MUX_FIXED_PRIORITY_EN

    // Fixed priority: the lowest-numbered requesting source wins.
    always_comb begin
        logic found;
        found   = 1'b0;
        w_grant = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && MuxReq[i]) begin
                found   = 1'b1;
                w_grant = SELECT_WIDTH'(i);
            end
        end
    end

`else

    logic [SELECT_WIDTH-1:0] r_last_grant;

    // Round-robin: scan last+1, last+2, ... wrapping modulo N. The last
    // granted index comes at the end of the scan (offset N), which is what
    // ranks a still-requesting source behind all the others.
    always_comb begin
        logic                    found;
        logic [SELECT_WIDTH-1:0] idx;
        found   = 1'b0;
        idx     = '0;
        w_grant = '0;
        for (int off = 1; off <= N; off++) begin
            idx = r_last_grant + SELECT_WIDTH'(off);
            if (!found && MuxReq[idx]) begin
                found   = 1'b1;
                w_grant = idx;
            end
        end
    end

    // Last-grant pointer: restarts so the first scan begins at index 0, and
    // only advances on an actual load (holds during backpressure).
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_last_grant <= SELECT_WIDTH'(N - 1);
        end else if (w_load) begin
            r_last_grant <= w_grant;
        end
    end

`endif

    // One-hot decode of the grant index, one bit per source.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_onehot
            assign w_grant_onehot[gi] = (w_grant == SELECT_WIDTH'(gi));
        end
    endgenerate

    // Output-register FSM: EMPTY -> FULL on load; FULL stays FULL on load or
    // stall and returns to EMPTY when the consumer takes the last transfer.
    // MuxOut/MuxSel keep their values when the register empties.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_EMPTY;
            r_out   <= 1'b0;
            r_sel   <= '0;
            r_ack   <= '0;
        end else begin
            r_ack <= '0;
            if (w_load) begin
                r_state <= ST_FULL;
                r_out   <= MuxIn[w_grant];
                r_sel   <= w_grant;
                r_ack   <= w_grant_onehot;
            end else begin
                case (r_state)
                    ST_EMPTY: r_state <= ST_EMPTY;
                    ST_FULL:  r_state <= MuxOutReady ? ST_EMPTY : ST_FULL;
                    default:  r_state <= ST_EMPTY;
                endcase
            end
        end
    end

    assign MuxOutValid = (r_state == ST_FULL);
    assign MuxOut      = r_out;
    assign MuxSel      = r_sel;
    assign MuxAck      = r_ack;

endmodule

// File: tb/tb_nbit_rr_mux.sv
// Directed bench for nbit_rr_mux with SELECT_WIDTH=4 (16 sources).
// Inputs change 1 ns after each rising edge; outputs are sampled there too.

module tb_nbit_rr_mux;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] MuxReq;
    logic [15:0] MuxIn;
    logic [15:0] MuxAck;
    logic        MuxOut;
    logic [3:0]  MuxSel;
    logic        MuxOutValid;
    logic        MuxOutReady;

    int tests = 0;
    int fails = 0;

    nbit_rr_mux #(.SELECT_WIDTH(4)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .MuxReq      (MuxReq),
        .MuxIn       (MuxIn),
        .MuxAck      (MuxAck),
        .MuxOut      (MuxOut),
        .MuxSel      (MuxSel),
        .MuxOutValid (MuxOutValid),
        .MuxOutReady (MuxOutReady)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic v, input logic [3:0] s,
                             input logic o, input logic [15:0] a);
        check({tag, ".valid"}, {15'd0, MuxOutValid}, {15'd0, v});
        check({tag, ".sel"},   {12'd0, MuxSel},      {12'd0, s});
        check({tag, ".out"},   {15'd0, MuxOut},      {15'd0, o});
        check({tag, ".ack"},   MuxAck,               a);
        $display("[TB] %s: valid=%0d sel=%0d out=%0d ack=%h", tag, MuxOutValid, MuxSel, MuxOut, MuxAck);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_sel;

        Reset       = 1'b1;
        MuxReq      = '0;
        MuxIn       = '0;
        MuxOutReady = 1'b0;
        step();
        step();
        Reset = 1'b0;

        // 1: idle after reset, ready toggling is ignored while empty
        for (int i = 0; i < 5; i++) begin
            MuxOutReady = i[0];
            step();
            check_all("t1_idle", 1'b0, 4'd0, 1'b0, 16'h0000);
        end

        // 2: single request on source 2
        MuxReq = 16'h0004; MuxIn = 16'h0004; MuxOutReady = 1'b1;
        step();
        check_all("t2_grant", 1'b1, 4'd2, 1'b1, 16'h0004);
        MuxReq = 16'h0000;
        step();
        check_all("t2_drain", 1'b0, 4'd2, 1'b1, 16'h0000);

        // stale data on unrequested lines is ignored
        MuxIn = 16'hFFFF;
        step();
        check_all("t2_stale", 1'b0, 4'd2, 1'b1, 16'h0000);

        // 3: two sources held high alternate
        do_reset();
        MuxReq = 16'h8001; MuxIn = 16'h8000; MuxOutReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
`ifdef MUX_FIXED_PRIORITY_EN
            exp_sel = 4'd0;
`else
            exp_sel = i[0] ? 4'd15 : 4'd0;
`endif
            check_all("t3_alt", 1'b1, exp_sel, exp_sel == 4'd15, 16'h0001 << exp_sel);
        end
        MuxReq = 16'h0000;
        step();
        check_all("t3_drain", 1'b0, exp_sel, exp_sel == 4'd15, 16'h0000);

        // 4: all request, backpressure holds source 0, then release
        do_reset();
        MuxReq = 16'hFFFF; MuxIn = 16'h5555; MuxOutReady = 1'b0;
        step();
        check_all("t4_first", 1'b1, 4'd0, 1'b1, 16'h0001);
        MuxIn = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            step();
            check_all("t4_stall", 1'b1, 4'd0, 1'b1, 16'h0000);
        end
        MuxIn = 16'h5555; MuxOutReady = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
`ifdef MUX_FIXED_PRIORITY_EN
            exp_sel = 4'd0;
`else
            exp_sel = 4'(i);
`endif
            check_all("t4_sweep", 1'b1, exp_sel, ~exp_sel[0], 16'h0001 << exp_sel);
        end
        MuxReq = 16'h0000;
        step();
        check_all("t4_drain", 1'b0, exp_sel, ~exp_sel[0], 16'h0000);

        // 5: reset while a stalled transfer is held
        do_reset();
        MuxReq = 16'h0020; MuxIn = 16'h0020; MuxOutReady = 1'b1;
        step();
        check_all("t5_grant", 1'b1, 4'd5, 1'b1, 16'h0020);
        MuxOutReady = 1'b0;
        Reset = 1'b1;
        step();
        check_all("t5_reset", 1'b0, 4'd0, 1'b0, 16'h0000);
        Reset = 1'b0;
        step();
        check_all("t5_regrant", 1'b1, 4'd5, 1'b1, 16'h0020);

        // 6: handshake with no pending request empties, data kept
        MuxReq = 16'h0000; MuxOutReady = 1'b1;
        step();
        check_all("t6_drain", 1'b0, 4'd5, 1'b1, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
